ase_pcie_ss_log_arbiter: RTL
============================

// Module: ase_pcie_ss_log_arbiter
// PURPOSE
//  Shares the single PCIe SS transaction-logger message-injection slot among N_REQ
//  monitor requesters (e.g. RX/TX/AFU-side TLP monitors), one message per cycle.
//  Per-requester 1-deep holding slots, round-robin grant, registered output with
//  valid/ready backpressure. Finish sequencing: drain pending messages, then signal done.
// PARAMETERS
//  N_REQ   4    number of requesters, 2..16
//  DATA_W  256  message payload width (encoded log record)
//  CNT_W   16   width of saturating dropped-message counter
// PORTS
//  clk           in   1              logger clock
//  SoftReset_n   in   1              asynchronous, active-low reset
//  req_valid     in   N_REQ          requester i offers a message
//  req_ready     out  N_REQ          requester i message accepted on this edge if valid
//  req_ts_en     in   N_REQ          requester i wants a timestamp prefix
//  req_data      in   N_REQ*DATA_W   payload, requester i at [i*DATA_W +: DATA_W]
//  log_valid     out  1              message presented to logger
//  log_ready     in   1              logger consumes message this edge
//  log_ts_en     out  1              timestamp enable for presented message
//  log_src       out  $clog2(N_REQ)  index of requester that owns log_data
//  log_data      out  DATA_W         presented payload
//  finish_req    in   1              level; request drain-and-stop
//  finish_done   out  1              sticky; all accepted messages delivered
//  drop_cnt      out  CNT_W          valid offers refused after finish_req, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): all slots empty; log_valid=0, log_ts_en=0,
//   log_src=0, log_data=0; finish_done=0; drop_cnt=0; rr_ptr=N_REQ-1; state=RUN.
//  Slot i: {full, ts_en, data}. Load when req_valid[i] & req_ready[i].
//  req_ready[i] = (state==RUN) & (~slot_full[i] | slot_pop[i]); slot_pop is a
//   combinational function of log_ready, so a requester can stream 1 msg/cycle.
//  Output register empty-or-draining: out_free = ~log_valid | log_ready.
//  Grant: when out_free, scan full slots starting at (rr_ptr+1) mod N_REQ, wrapping;
//   first full slot wins, slot_pop[win]=1, output reg loads {ts_en,win,data},
//   rr_ptr<=win. No full slot and out_free: log_valid<=0 (others hold old value).
//  log_valid held with stable log_ts_en/log_src/log_data until log_ready.
//  Latency: message accepted at edge k is visible on log_valid after edge k+1 at the
//   earliest (uncontended, out_free). No message is ever lost or duplicated.
//  Fairness: with all N_REQ slots continuously full and log_ready=1, grants cycle
//   0,1,..,N_REQ-1,0,...; any full slot is granted within N_REQ output transfers.
//  FSM: RUN -(finish_req)-> DRAIN -(all slots empty & ~log_valid)-> DONE.
//   RUN->DRAIN on first cycle finish_req=1; req_ready=0 in DRAIN/DONE.
//   DRAIN: grants continue until empty. DONE: finish_done=1 until reset; finish_req
//   deassertion ignored after leaving RUN. If finish_req rises while everything is
//   already empty, DRAIN->DONE on the next edge (finish_done 2 edges after request).
//  drop_cnt: +popcount is NOT used; increments by 1 per cycle in which any
//   req_valid=1 while state!=RUN; saturates at 2**CNT_W-1, never wraps.
//  Simultaneous load and pop of same slot: pop old content, load new; slot stays full.
//  Reset mid-operation: pending slot/output contents discarded, outputs to reset values.
// TESTING
//  1. Single req0 valid 1 cycle, data=0xA5, ts_en=1, log_ready=1 -> log_valid 1 cycle
//     after acceptance edge +1, log_src=0, log_data=0xA5, log_ts_en=1.
//  2. N_REQ=4 all valid continuously, log_ready=1 -> log_src sequence 0,1,2,3,0,1,...
//     and each req_ready=1 every 4th cycle.
//  3. log_ready=0 for 10 cycles with log_valid=1 -> log_data/log_src stable; at most
//     one msg per requester accepted into slots; all delivered in order after release.
//  4. req2 streams 8 msgs back-to-back alone, log_ready=1 -> 8 consecutive log_valid
//     cycles, data in order, req_ready[2] constantly 1.
//  5. 3 slots full, assert finish_req, req_valid=1 for 5 more cycles -> 3 msgs drained,
//     req_ready=0, drop_cnt=5, finish_done=1 after last log transfer +1 edge.
//  6. Assert SoftReset_n=0 mid-burst with log_valid=1 -> log_valid=0 immediately
//     (async), drop_cnt=0; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/ase_pcie_ss_log_arbiter_if.sv
// ase_pcie_ss_log_arbiter_if
//  Bundles the requester-side and logger-side signals of the PCIe SS log arbiter.
//  master : arbiter view (drives req_ready, log_*, finish_done, drop_cnt)
//  slave  : environment view (drives req_*, log_ready, finish_req)
//  req_valid/req_ready/req_ts_en/req_data : per-requester offer, data at [i*DATA_W +: DATA_W]
//  log_valid/log_ready/log_ts_en/log_src/log_data : registered message toward the logger
//  finish_req/finish_done : drain-and-stop request and sticky completion flag
//  drop_cnt : saturating count of cycles with offers refused after finish_req
interface ase_pcie_ss_log_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_ts_en;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    log_valid;
    logic                    log_ready;
    logic                    log_ts_en;
    logic [SRC_W-1:0]        log_src;
    logic [DATA_W-1:0]       log_data;
    logic                    finish_req;
    logic                    finish_done;
    logic [CNT_W-1:0]        drop_cnt;

    modport master (
        input  req_valid, req_ts_en, req_data, log_ready, finish_req,
        output req_ready, log_valid, log_ts_en, log_src, log_data, finish_done, drop_cnt
    );

    modport slave (
        output req_valid, req_ts_en, req_data, log_ready, finish_req,
        input  req_ready, log_valid, log_ts_en, log_src, log_data, finish_done, drop_cnt
    );
endinterface

// File: rtl/ase_pcie_ss_log_arbiter.sv
// ase_pcie_ss_log_arbiter
//  Shares the single transaction-logger message slot among N_REQ monitor requesters.
//  Each requester owns a 1-deep holding slot; a round-robin scan picks one full slot per
//  cycle into a registered output stage with valid/ready backpressure. finish_req stops
//  acceptance, drains pending messages, then raises the sticky finish_done.
//  Ports:
//   clk         logger clock
//   SoftReset_n asynchronous active-low reset
//   bus         ase_pcie_ss_log_arbiter_if.master (requester, logger and finish signals)
module ase_pcie_ss_log_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        SoftReset_n,
    ase_pcie_ss_log_arbiter_if.master   bus
);
    localparam int unsigned SRC_W = $clog2(N_REQ);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [N_REQ-1:0]  slot_full_q;
    logic [N_REQ-1:0]  slot_ts_q;
    logic [DATA_W-1:0] slot_data_q [N_REQ];

    logic              log_valid_q;
    logic              log_ts_en_q;
    logic [SRC_W-1:0]  log_src_q;
    logic [DATA_W-1:0] log_data_q;
    logic [SRC_W-1:0]  rr_ptr_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic              out_free;
    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;
    logic [N_REQ-1:0]  slot_pop;
    logic [N_REQ-1:0]  slot_load;
    logic [N_REQ-1:0]  req_ready;

    // Output stage can take a new message if empty or being consumed this edge.
    assign out_free = ~log_valid_q | bus.log_ready;

    // Round-robin scan starting one past the last winner, wrapping.
    always_comb begin : grant_scan
        int unsigned      idx;
        logic [SRC_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx  = (32'(rr_ptr_q) + 32'd1 + k) % N_REQ;
            cand = SRC_W'(idx);
            if (!grant_vld && slot_full_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Pop is combinational on log_ready so a slot can refill in the cycle it drains.
    always_comb begin
        slot_pop  = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            slot_pop[i]  = out_free & grant_vld & (grant_idx == SRC_W'(i));
            req_ready[i] = (state_q == StRun) & (~slot_full_q[i] | slot_pop[i]);
        end
        slot_load = bus.req_valid & req_ready;
    end

    // Load wins over pop so a simultaneous pop/load leaves the slot full with new content.
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            slot_full_q <= '0;
            slot_ts_q   <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (slot_load[i]) begin
                    slot_full_q[i] <= 1'b1;
                    slot_ts_q[i]   <= bus.req_ts_en[i];
                    slot_data_q[i] <= bus.req_data[i*DATA_W +: DATA_W];
                end else if (slot_pop[i]) begin
                    slot_full_q[i] <= 1'b0;
                end
            end
        end
    end

    // Output register; payload fields hold their last value when nothing is granted.
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            log_valid_q <= 1'b0;
            log_ts_en_q <= 1'b0;
            log_src_q   <= '0;
            log_data_q  <= '0;
            rr_ptr_q    <= SRC_W'(N_REQ - 1);
        end else if (out_free) begin
            if (grant_vld) begin
                log_valid_q <= 1'b1;
                log_ts_en_q <= slot_ts_q[grant_idx];
                log_src_q   <= grant_idx;
                log_data_q  <= slot_data_q[grant_idx];
                rr_ptr_q    <= grant_idx;
            end else begin
                log_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (bus.finish_req) state_d = StDrain;
            StDrain: if (~|slot_full_q && !log_valid_q) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // One count per cycle with any refused offer, regardless of how many requesters.
    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            drop_cnt_q <= '0;
        end else if ((state_q != StRun) && (|bus.req_valid) && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.log_valid   = log_valid_q;
    assign bus.log_ts_en   = log_ts_en_q;
    assign bus.log_src     = log_src_q;
    assign bus.log_data    = log_data_q;
    assign bus.finish_done = (state_q == StDone);
    assign bus.drop_cnt    = drop_cnt_q;
endmodule
